// File: rtl/ctrl_bubble_stage.sv
// ID/EX control register that inserts load-use bubbles, single or multi-cycle,
// with flush/hold priority and a saturating count of inserted bubbles.
module ctrl_bubble_stage #(
  parameter int CTRL_W = 14,
  parameter int LEN_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              bubble_req,
  input  logic [LEN_W-1:0]  bubble_len,
  input  logic              flush,
  input  logic              hold,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              valid_out,
  output logic              stall_fe,
  output logic              busy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic {IDLE, BUBBLE} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_eff;
  logic [CNT_W-1:0]    cnt_inc;

  assign len_eff = (bubble_len == '0) ? LEN_W'(1) : bubble_len;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (hold) begin
      // everything retains
    end else if (state_q == BUBBLE) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      cnt_d   = cnt_inc;
      // rem<=1 also covers a stray zero so the counter never underflows
      if (rem_q <= LEN_W'(1)) begin
        state_d = IDLE;
        rem_d   = '0;
      end else begin
        rem_d = rem_q - LEN_W'(1);
      end
    end else if (bubble_req) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      cnt_d   = cnt_inc;
      if (len_eff > LEN_W'(1)) begin
        state_d = BUBBLE;
        rem_d   = len_eff - LEN_W'(1);
      end
    end else begin
      ctrl_d  = ctrl_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = !rst && (state_q == BUBBLE);
  assign stall_fe   = !rst && !flush &&
                      (hold || (state_q == BUBBLE) || ((state_q == IDLE) && bubble_req));
  assign ctrl_out   = ctrl_q;
  assign valid_out  = valid_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_bubble_stage.sv
// Directed-vector bench for ctrl_bubble_stage; a second CNT_W=2 instance
// shares the stimulus to exercise counter saturation.
module tb_ctrl_bubble_stage;

  logic        clk = 1'b0;
  logic        rst, bubble_req, flush, hold;
  logic [13:0] ctrl_in;
  logic [2:0]  bubble_len;
  logic [13:0] ctrl_out, s_ctrl_out;
  logic        valid_out, stall_fe, busy;
  logic        s_valid_out, s_stall_fe, s_busy;
  logic [15:0] bubble_cnt;
  logic [1:0]  s_bubble_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  ctrl_bubble_stage #(.CTRL_W(14), .LEN_W(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .bubble_req(bubble_req),
    .bubble_len(bubble_len), .flush(flush), .hold(hold),
    .ctrl_out(ctrl_out), .valid_out(valid_out), .stall_fe(stall_fe),
    .busy(busy), .bubble_cnt(bubble_cnt)
  );

  ctrl_bubble_stage #(.CTRL_W(14), .LEN_W(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .ctrl_in(ctrl_in), .bubble_req(bubble_req),
    .bubble_len(bubble_len), .flush(flush), .hold(hold),
    .ctrl_out(s_ctrl_out), .valid_out(s_valid_out), .stall_fe(s_stall_fe),
    .busy(s_busy), .bubble_cnt(s_bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [13:0] c, input logic v,
                         input logic [15:0] n, input logic b);
    check({tag, ".ctrl"},  32'(ctrl_out),   32'(c));
    check({tag, ".valid"}, 32'(valid_out),  32'(v));
    check({tag, ".cnt"},   32'(bubble_cnt), 32'(n));
    check({tag, ".busy"},  32'(busy),       32'(b));
  endtask

  logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst = 1'b1; ctrl_in = 14'h3FFF; bubble_req = 1'b1; bubble_len = 3'd3;
    flush = 1'b0; hold = 1'b1;
    #1;
    check("rst_pre.stall", 32'(stall_fe), 32'd0);
    check("rst_pre.busy",  32'(busy),     32'd0);
    tick(); tick();
    chk_out("rst", 14'h0, 1'b0, 16'd0, 1'b0);
    check("rst.stall", 32'(stall_fe), 32'd0);

    // pass-through
    rst = 1'b0; bubble_req = 1'b0; hold = 1'b0; ctrl_in = 14'h2A5;
    #1 check("pass_pre.stall", 32'(stall_fe), 32'd0);
    tick();
    chk_out("pass", 14'h2A5, 1'b1, 16'd0, 1'b0);
    check("pass.stall", 32'(stall_fe), 32'd0);

    // single bubble, len 0 treated as 1
    bubble_req = 1'b1; bubble_len = 3'd0; ctrl_in = 14'h111;
    #1 check("single_pre.stall", 32'(stall_fe), 32'd1);
    tick();
    chk_out("single", 14'h0, 1'b0, 16'd1, 1'b0);
    bubble_req = 1'b0;
    #1 check("single_post.stall", 32'(stall_fe), 32'd0);
    tick();
    chk_out("single_pass", 14'h111, 1'b1, 16'd1, 1'b0);

    // three-cycle bubble
    bubble_req = 1'b1; bubble_len = 3'd3; ctrl_in = 14'h222;
    tick();
    chk_out("multi1", 14'h0, 1'b0, 16'd2, 1'b1);
    bubble_req = 1'b0;
    #1 check("multi1.stall", 32'(stall_fe), 32'd1);
    tick();
    chk_out("multi2", 14'h0, 1'b0, 16'd3, 1'b1);
    check("multi2.stall", 32'(stall_fe), 32'd1);
    tick();
    chk_out("multi3", 14'h0, 1'b0, 16'd4, 1'b0);
    check("multi3.stall", 32'(stall_fe), 32'd0);
    tick();
    chk_out("multi_pass", 14'h222, 1'b1, 16'd4, 1'b0);

    // request held high during BUBBLE must not extend it
    bubble_req = 1'b1; bubble_len = 3'd2;
    tick();
    chk_out("noext1", 14'h0, 1'b0, 16'd5, 1'b1);
    bubble_len = 3'd7;
    tick();
    bubble_req = 1'b0;
    chk_out("noext2", 14'h0, 1'b0, 16'd6, 1'b0);
    tick();
    chk_out("noext_pass", 14'h222, 1'b1, 16'd6, 1'b0);

    // hold inside a four-cycle bubble
    bubble_req = 1'b1; bubble_len = 3'd4; ctrl_in = 14'h333;
    tick();
    bubble_req = 1'b0; hold = 1'b1;
    chk_out("hold_b1", 14'h0, 1'b0, 16'd7, 1'b1);
    tick();
    chk_out("hold_h1", 14'h0, 1'b0, 16'd7, 1'b1);
    check("hold_h1.stall", 32'(stall_fe), 32'd1);
    tick();
    hold = 1'b0;
    chk_out("hold_h2", 14'h0, 1'b0, 16'd7, 1'b1);
    tick();
    chk_out("hold_b2", 14'h0, 1'b0, 16'd8, 1'b1);
    tick();
    chk_out("hold_b3", 14'h0, 1'b0, 16'd9, 1'b1);
    tick();
    chk_out("hold_b4", 14'h0, 1'b0, 16'd10, 1'b0);
    tick();
    chk_out("hold_pass", 14'h333, 1'b1, 16'd10, 1'b0);
    // hold freezes a valid instruction and ignores bubble_req
    hold = 1'b1; bubble_req = 1'b1; ctrl_in = 14'h3AB;
    tick();
    chk_out("hold_valid", 14'h333, 1'b1, 16'd10, 1'b0);
    hold = 1'b0; bubble_req = 1'b0;

    // flush aborts a five-cycle bubble
    bubble_req = 1'b1; bubble_len = 3'd5; ctrl_in = 14'h444;
    tick();
    chk_out("flush_b1", 14'h0, 1'b0, 16'd11, 1'b1);
    bubble_req = 1'b0; flush = 1'b1;
    #1 check("flush.stall", 32'(stall_fe), 32'd0);
    tick();
    chk_out("flush1", 14'h0, 1'b0, 16'd11, 1'b0);
    bubble_req = 1'b1;
    #1 check("flush_req.stall", 32'(stall_fe), 32'd0);
    tick();
    chk_out("flush_req", 14'h0, 1'b0, 16'd11, 1'b0);
    flush = 1'b0; bubble_req = 1'b0;
    tick();
    chk_out("flush_pass", 14'h444, 1'b1, 16'd11, 1'b0);

    // reset mid-bubble
    bubble_req = 1'b1; bubble_len = 3'd3; ctrl_in = 14'h555;
    tick();
    chk_out("rstmid_b1", 14'h0, 1'b0, 16'd12, 1'b1);
    rst = 1'b1;
    #1;
    check("rstmid.busy",  32'(busy),     32'd0);
    check("rstmid.stall", 32'(stall_fe), 32'd0);
    tick();
    rst = 1'b0; bubble_req = 1'b0;
    chk_out("rstmid", 14'h0, 1'b0, 16'd0, 1'b0);
    tick();
    chk_out("rstmid_pass", 14'h555, 1'b1, 16'd0, 1'b0);

    // saturation on the two-bit counter instance
    bubble_req = 1'b1; bubble_len = 3'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("sat%0d", i), 32'(s_bubble_cnt), 32'(exp_sat[i]));
    end
    check("sat.wide_cnt", 32'(bubble_cnt), 32'd5);
    bubble_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_bubble_stage.md
CTRL_BUBBLE_STAGE -- requirements
Module: ctrl_bubble_stage

Interface
REQ-001 SHALL have parameter CTRL_W, default 14: width of the ID/EX control bundle.
REQ-002 SHALL have parameter LEN_W, default 3: width of the bubble-length field.
REQ-003 SHALL have parameter CNT_W, default 16: width of the bubble statistics counter.
REQ-004 SHALL have port clk  input  1: sole clock, rising-edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port ctrl_in  input  CTRL_W: decoded control bundle from ID.
REQ-007 SHALL have port bubble_req  input  1: load-use hazard request.
REQ-008 SHALL have port bubble_len  input  LEN_W: number of bubble cycles requested, with 0 treated as 1.
REQ-009 SHALL have port flush  input  1: branch/jump kill.
REQ-010 SHALL have port hold  input  1: global pipeline freeze.
REQ-011 SHALL have port ctrl_out  output  CTRL_W: registered control bundle to EX.
REQ-012 SHALL have port valid_out  output  1: ctrl_out carries a real instruction.
REQ-013 SHALL have port stall_fe  output  1: freeze PC and IF/ID.
REQ-014 SHALL have port busy  output  1: multi-cycle bubble in progress.
REQ-015 SHALL have port bubble_cnt  output  CNT_W: saturating count of bubbles inserted.

Function
REQ-016 SHALL implement a two-state FSM {IDLE, BUBBLE} plus a LEN_W-bit remaining counter rem.
REQ-017 SHALL apply per-edge priority: rst > flush > hold > bubble (IDLE with bubble_req, or BUBBLE) > pass.
REQ-018 On pass (IDLE, no bubble_req): SHALL set ctrl_out <= ctrl_in and valid_out <= 1, so latency is 1 cycle.
REQ-019 On a bubble edge: SHALL set ctrl_out <= all-zero and valid_out <= 0.
REQ-020 On IDLE with bubble_req and effective length L (1..2^LEN_W-1): SHALL insert one bubble.
REQ-021 In the same case: if L>1, SHALL set rem <= L-1 and go to BUBBLE; if L=1, SHALL stay IDLE.
REQ-022 In BUBBLE: SHALL insert one bubble per edge and decrement rem.
REQ-023 In BUBBLE: when rem==1 at the edge, SHALL return to IDLE with rem <= 0.
REQ-024 SHALL ignore bubble_req while in BUBBLE, with no re-arm and no extension.
REQ-025 SHALL generate stall_fe combinationally as !flush & (hold | state==BUBBLE | (state==IDLE & bubble_req)).
REQ-026 SHALL generate busy combinationally as state==BUBBLE.
REQ-027 On flush: SHALL set ctrl_out <= 0, valid_out <= 0, state <= IDLE and rem <= 0, aborting any bubble sequence.
REQ-028 A flush SHALL NOT increment bubble_cnt.
REQ-029 On hold without flush: ctrl_out, valid_out, state, rem and bubble_cnt SHALL all retain their values.
REQ-030 On hold without flush: bubble_req SHALL be ignored for that edge.
REQ-031 bubble_cnt SHALL increment by 1 on every bubble edge and saturate at 2^CNT_W-1 with no wrap.
REQ-032 SHALL treat all arithmetic on rem and bubble_cnt as unsigned, and rem SHALL never underflow.
REQ-033 Simultaneous bubble_req and flush in IDLE: flush SHALL win, with no bubble counted and no BUBBLE entry.

Reset
REQ-034 With rst high at an edge: SHALL set ctrl_out=0, valid_out=0, state=IDLE, rem=0 and bubble_cnt=0.
REQ-035 While rst is high: SHALL hold stall_fe=0 and busy=0 regardless of other inputs.
REQ-036 Reset mid-BUBBLE SHALL abort the sequence, and on the first edge after release the block SHALL pass ctrl_in.

Verification
REQ-037 Pass-through: rst release, ctrl_in=14'h2A5 with no requests -> next edge ctrl_out=14'h2A5, valid_out=1, stall_fe=0.
REQ-038 Single bubble: bubble_req=1, bubble_len=0 for 1 cycle -> one zero cycle, valid_out=0, bubble_cnt=1, busy never high, stall_fe high for that cycle only.
REQ-039 Multi-bubble: bubble_len=3 -> 3 consecutive zero cycles, busy high for cycles 2-3, stall_fe high for 3 cycles, bubble_cnt +3, then ctrl_in passes.
REQ-040 Hold inside bubble: bubble_len=4 with hold on the 2nd cycle for 2 cycles -> 4 bubbles total over 6 cycles, ctrl_out frozen during hold, bubble_cnt +4.
REQ-041 Flush abort: flush asserted on the 2nd cycle of bubble_len=5 -> IDLE next edge, busy=0, bubble_cnt +1 only, and flush+bubble_req together count nothing.
REQ-042 Saturation: CNT_W=2, 5 single bubbles -> bubble_cnt sequence 1,2,3,3,3.
